// File: rtl/rand_pkg.sv
// Shared types and LFSR tap table for the random sampler.
// Mode and FSM state encodings live here so every stage agrees.
package rand_pkg;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_SINGLE = 2'b10,
    MODE_BURST  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_BURST = 2'b10
  } state_e;

  localparam int MIN_W = 3;
  localparam int MAX_W = 16;

  // Maximal-length tap masks, bit n-1 set for tap n.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0006;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR, shifts left with XOR feedback into bit 0.
// Reseeding with zero loads 1 so the lock-up state is unreachable.
module lfsr_gen
  import rand_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS =
    WIDTH'(lfsr_taps(WIDTH));

  logic fb;

  assign fb = ^(value & TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= WIDTH'(1);
    end else if (load) begin
      value <= (seed == '0) ? WIDTH'(1) : seed;
    end else begin
      value <= {value[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/rand_sampler.sv
// Tick-paced sampler of a free-running LFSR with
// free, hold, single-shot and burst capture modes.
module rand_sampler
  import rand_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int DIV_W     = 24,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] period,
  input  logic [1:0]       mode,
  input  logic             trigger,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             tick_sq,
  output logic             busy
);

  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);

  logic [WIDTH-1:0] lfsr_val;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             trig_d;
  logic             trig_rise;
  logic [1:0]       mode_d;
  logic             mode_chg;
  mode_e            md;
  state_e           state;
  state_e           state_nxt;
  logic [7:0]       bcnt;
  logic [7:0]       bcnt_nxt;
  logic             cap;

  lfsr_gen #(
    .WIDTH(WIDTH)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (seed_load),
    .seed (seed_in),
    .value(lfsr_val)
  );

  assign md        = mode_e'(mode);
  assign mode_chg  = (mode != mode_d);
  assign trig_rise = trigger & ~trig_d;
  assign busy      = (state != ST_IDLE);

  // >= so a period lowered below the count wraps at once
  assign tick = (period <= DIV_W'(1)) ||
                (cnt >= period - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tick_sq <= 1'b0;
      trig_d  <= 1'b0;
      mode_d  <= MODE_FREE;
    end else begin
      cnt     <= tick ? '0 : cnt + DIV_W'(1);
      trig_d  <= trigger;
      mode_d  <= mode;
      if (tick) begin
        tick_sq <= ~tick_sq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // A mode change idles the FSM and blocks capture for one cycle
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    cap       = 1'b0;
    if (mode_chg) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (md)
        MODE_FREE: begin
          state_nxt = ST_IDLE;
          cap       = tick;
        end
        MODE_HOLD: begin
          state_nxt = ST_IDLE;
        end
        MODE_SINGLE: begin
          case (state)
            ST_IDLE: begin
              if (trig_rise) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
              if (tick) begin
                cap       = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
        MODE_BURST: begin
          case (state)
            ST_IDLE: begin
              if (trig_rise) begin
                state_nxt = ST_BURST;
                bcnt_nxt  = '0;
              end
            end
            ST_BURST: begin
              if (tick) begin
                cap = 1'b1;
                if (bcnt == LAST) state_nxt = ST_IDLE;
                else bcnt_nxt = bcnt + 8'd1;
              end
            end
            default: state_nxt = ST_IDLE;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= cap;
      if (cap) begin
        sample <= lfsr_val;
      end
    end
  end

endmodule
